// File: rtl/riscv_pkg.sv
// Shared definitions for the 32I core front end.
//   XLEN             - architectural register / address width
//   RESET_PC_DEFAULT - fetch address after reset unless a block overrides it
//   NOP              - canonical no-op (addi x0, x0, 0)
//   fetch_entry_t    - one buffered fetch result: instruction word plus its PC
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched words between imem and decode.
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   flush             - drops every entry; wins over push and pop in the same cycle
//   push, push_data   - write one entry; accepted when not full, or when full and popping
//   pop, pop_data     - pop_data is the head entry (combinational read); pop ignored when empty
//   count/empty/full  - occupancy
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic [PtrW:0]    count,
  output logic             empty,
  output logic             full
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PtrW + 1)'(Depth));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues sequential imem requests under a credit
// scheme, buffers responses with their PC and hands them to decode. A redirect reloads both
// PCs, flushes the buffer and arranges for every request already in flight to be discarded.
//   clk, reset                        - rising-edge clock, asynchronous active-high reset
//   pc_src, branch_addr               - redirect request and target (low 2 bits ignored)
//   req_valid, req_ready, req_addr    - imem request channel (req_addr is the fetch PC)
//   resp_valid, resp_data             - in-order imem responses, always accepted
//   inst_valid, inst_ready            - decode handshake
//   inst, inst_pc, inst_pc4           - head instruction, its PC, and PC + 4
module if_fetch_unit import riscv_pkg::*; #(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_addr,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4
);

  localparam int unsigned     CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] Four      = XLEN'(4);
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     in_use;
  logic              fifo_empty, fifo_full;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0]   head_pc, head_inst, target;
  logic              credit, issue, resp_keep, pop;

  fetch_fifo #(
    .Width (2 * XLEN),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (pc_src),
    .push      (resp_keep),
    .push_data ({resp_pc_q, resp_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Handshake glue. Every in-flight request reserves a buffer slot, so responses never overflow.
  always_comb begin
    in_use     = {1'b0, outstanding_q} + {1'b0, fifo_count};
    credit     = in_use < (CntW + 1)'(FIFO_DEPTH);
    req_valid  = !reset && !pc_src && credit;
    issue      = req_valid && req_ready;
    resp_keep  = resp_valid && !pc_src && (drop_cnt_q == '0);
    inst_valid = !pc_src && !fifo_empty;
    pop        = inst_valid && inst_ready;
    target     = branch_addr & AlignMask;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CntW'(issue) - CntW'(resp_valid);
    if (pc_src) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      // outstanding already includes any still-pending stale requests, so after a redirect
      // the whole in-flight set is stale, less the response retired this cycle.
      drop_cnt_d = outstanding_q - CntW'(resp_valid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + Four;
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + Four;
      end else if (resp_valid) begin
        drop_cnt_d = drop_cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign {head_pc, head_inst} = fifo_head;
  assign req_addr = fetch_pc_q;
  assign inst     = fifo_empty ? '0 : head_inst;
  assign inst_pc  = fifo_empty ? '0 : head_pc;
  assign inst_pc4 = fifo_empty ? '0 : head_pc + Four;

  // Credits must make a push into a full buffer impossible unless the head leaves too.
  no_overflow_a : assert property (@(posedge clk) disable iff (reset)
    !(resp_keep && fifo_full && !pop));

endmodule
